window_frame_collector: RTL
===========================

// Module: window_frame_collector
// PURPOSE
// - Downstream end of the windowing stage. Captures the windowed sample pairs (out1/out2) into a two-bank frame buffer.
// - Each frame is armed by the windowing 'next' pulse.
// - Replays each completed frame as a one-sample-per-cycle valid/ready stream, in index order, to the FFT loader.
// - Ping-pong banks let frame N+1 fill while frame N drains.
// PARAMETERS
// - DATA_W     12    sample width (two's complement, passed through unmodified)
// - FRAME_LEN  2048  samples per frame; must be even and a power of 2
// - ADDR_W     11    log2(FRAME_LEN)
// PORTS
// - clk          in   1       single clock; all logic on posedge
// - rst          in   1       asynchronous, active-high reset
// - frame_start  in   1       'next' from windowing; rising edge arms a new frame
// - in_valid     in   1       in1/in2 carry a valid pair this cycle
// - in1          in   DATA_W  even-index sample (index 2k)
// - in2          in   DATA_W  odd-index sample (index 2k+1)
// - out_data     out  DATA_W  streamed sample
// - out_valid    out  1       out_data valid
// - out_ready    in   1       downstream accepts when out_valid & out_ready
// - out_last     out  1       high with sample FRAME_LEN-1
// - overflow     out  1       one-cycle pulse: frame dropped, no free bank
// - state        out  3       {rd_active, wr_state[1:0]} for debug
// BEHAVIOUR
// - Reset values: out_data=0, out_valid=0, out_last=0, overflow=0, state=0.
//   Both banks empty; wr_bank=0; rd_bank=0; all counters 0.
// - Edge detect: frame_start is registered once; arming occurs on the 0->1 transition only.
// - Write FSM: W_IDLE(0) -> W_FILL(1) -> W_DONE(2) -> W_IDLE.
//   - W_IDLE, rising frame_start, bank wr_bank empty: go to W_FILL, wr_addr=0.
//   - W_IDLE, rising frame_start, bank wr_bank full: stay in W_IDLE. Pulse overflow; the whole frame's pairs are ignored.
//   - W_FILL, in_valid=1: write in1 -> mem[wr_bank][wr_addr], in2 -> mem[wr_bank][wr_addr+1], wr_addr += 2.
//   - W_FILL: the pair landing at wr_addr = FRAME_LEN-2 completes the frame -> W_DONE.
//   - W_DONE: mark wr_bank full, toggle wr_bank, go to W_IDLE (1 cycle).
//   - frame_start edges while in W_FILL/W_DONE are ignored. in_valid outside W_FILL is ignored.
// - Read side: R_IDLE / R_STREAM (state[2]).
//   - R_IDLE with bank rd_bank full: enter R_STREAM, rd_addr=0.
//   - RAM read is registered (1-cycle latency). A prefetch register keeps a full-throughput stream with out_ready held high.
//   - out_data/out_valid/out_last hold stable while out_valid & !out_ready.
//   - Transfer of sample FRAME_LEN-1: mark rd_bank empty, toggle rd_bank, go to R_IDLE.
//   - A back-to-back next frame may start streaming on the following cycle.
// - Latency: first out_valid is 3 cycles after the W_DONE cycle of the first frame, given an empty pipeline.
// - Simultaneous events: the reader releasing a bank and the writer arming it in the same cycle resolves to free.
//   The release is visible to the writer that cycle, so no false overflow.
// - Address wrap: the write and read counters never pass FRAME_LEN-1; they reset to 0 at each frame start.
// - Reset mid-frame: the partial frame is discarded, both banks are emptied, and the stream stops immediately (out_valid=0).
// CONFIGURATION
// - `define COLLECTOR_OVERFLOW_CNT_EN adds an output drop_count [15:0].
//   - It increments on each overflow pulse, saturates at 16'hFFFF, and clears only on rst.
// - Without the macro: the port and counter are absent; only the overflow pulse is provided.
// TESTING
// - Single frame: in1=in2=12'h400 with a 2-cycle pair cadence after one frame_start.
//   -> 2048 outputs of 12'h400, out_last only on the 2048th, overflow never set.
// - Ramp: in1=2k, in2=2k+1 for k=0..1023 -> out_data equals sample index 0..2047 in order.
// - Backpressure: toggle out_ready with a random 50% duty.
//   -> no sample lost or duplicated; out_data stable while stalled.
// - Ping-pong: two frames back-to-back with out_ready=0 until both are captured.
//   -> a third frame_start pulses overflow once.
//   -> after release, frames 1 and 2 stream in order.
// - Reset mid-frame: assert rst at pair 500.
//   -> outputs go to zero asynchronously; the next full frame streams correctly from index 0.
// - With COLLECTOR_OVERFLOW_CNT_EN: 3 forced overflows -> drop_count=3; after rst, drop_count=0.

Source files
------------

// File: rtl/window_frame_collector.sv
// -----------------------------------------------------------------------------
// window_frame_collector
//
// Purpose:
//   Downstream end of the windowing stage. Windowed sample pairs (in1 = even
//   index, in2 = odd index) are captured into a two-bank (ping-pong) frame
//   buffer. Each frame is armed by a rising edge on frame_start. Every
//   completed frame is replayed in index order as a one-sample-per-cycle
//   valid/ready stream towards the FFT loader. One bank can fill while the
//   other drains.
//
// Ports:
//   clk          in   1       single clock, all logic on posedge
//   rst          in   1       asynchronous, active-high reset
//   frame_start  in   1       rising edge arms a new frame
//   in_valid     in   1       in1/in2 carry a valid pair this cycle
//   in1          in   DATA_W  even-index sample (2k)
//   in2          in   DATA_W  odd-index sample (2k+1)
//   out_data     out  DATA_W  streamed sample
//   out_valid    out  1       out_data valid
//   out_ready    in   1       downstream accepts when out_valid & out_ready
//   out_last     out  1       high with sample FRAME_LEN-1
//   overflow     out  1       one-cycle pulse: frame dropped, no free bank
//   state        out  3       {rd_active, wr_state[1:0]} for debug
//   drop_count   out  16      only with COLLECTOR_OVERFLOW_CNT_EN defined:
//                             saturating count of overflow pulses
//
// Optional feature macro: COLLECTOR_OVERFLOW_CNT_EN
// -----------------------------------------------------------------------------
module window_frame_collector #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow,
    output logic [2:0]        state
`ifdef COLLECTOR_OVERFLOW_CNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] PAIR_LAST = ADDR_W'(FRAME_LEN - 2);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DONE = 2'd2
    } wr_state_t;

    // ---------------------------------------------------------------- write side
    wr_state_t         wr_state;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        bank_full;
    logic              fs_reg;
    logic              fs_rise;
    logic              bank_free;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;

    // ----------------------------------------------------------------- read side
    logic              rd_active;
    logic              rd_bank;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_done;
    logic              start;
    logic              pop;
    logic              release_bank;
    logic [1:0]        occ;
    logic              fetch_ok;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_eff;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_odd;
    logic              rd_is_last;

    // RAM output register stage (one read in flight at most)
    logic              ram_valid;
    logic              ram_last;
    logic              ram_odd;
    logic [DATA_W-1:0] ram_data;

    // Prefetch register: catches the in-flight read when the output stalls
    logic              skid_valid;
    logic              skid_last;
    logic [DATA_W-1:0] skid_data;

    logic [DATA_W-1:0] lane_wdata [2];
    logic [DATA_W-1:0] lane_q     [2];

    assign fs_rise = frame_start & ~fs_reg;
    assign wr_en   = (wr_state == W_FILL) && in_valid;
    assign wr_idx  = {wr_bank, wr_addr[ADDR_W-1:1]};

    assign pop          = out_valid & out_ready;
    assign release_bank = pop & out_last;

    // A bank the reader releases this very cycle already counts as free for
    // the writer, so a coincident arm never reports a false overflow.
    assign bank_free = ~bank_full[wr_bank] | (release_bank & (rd_bank == wr_bank));

    // Items held or in flight: output register, prefetch register, RAM stage.
    // A new read is only issued when, after this cycle's pop, at most one slot
    // is taken; that keeps out + prefetch from ever overflowing while still
    // sustaining one sample per cycle with out_ready high.
    assign occ      = 2'(out_valid) + 2'(skid_valid) + 2'(ram_valid);
    assign fetch_ok = (occ - 2'(pop)) <= 2'd1;

    // Sample 0 is fetched in the same cycle the reader leaves R_IDLE so the
    // first sample is presented three cycles after the writer's W_DONE cycle.
    assign start       = ~rd_active & bank_full[rd_bank];
    assign rd_en       = start | (rd_active & ~fetch_done & fetch_ok);
    assign rd_addr_eff = start ? '0 : fetch_addr;
    assign rd_idx      = {rd_bank, rd_addr_eff[ADDR_W-1:1]};
    assign rd_odd      = rd_addr_eff[0];
    assign rd_is_last  = (rd_addr_eff == LAST_ADDR);

    assign lane_wdata[0] = in1;
    assign lane_wdata[1] = in2;

    // Two sample lanes (even / odd index), each a plain dual-port array with
    // one write and one registered read per cycle. The writer and reader
    // always address different banks, so no read-during-write hazard exists.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [0:FRAME_LEN-1];
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_idx] <= lane_wdata[gi];
                end
                if (rd_en) begin
                    q_reg <= mem[rd_idx];
                end
            end

            assign lane_q[gi] = q_reg;
        end
    endgenerate

    assign ram_data = ram_odd ? lane_q[1] : lane_q[0];

    assign state = {rd_active, wr_state};

    // ------------------------------------------------------------- write FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state   <= W_IDLE;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            bank_full  <= 2'b00;
            fs_reg     <= 1'b0;
            overflow   <= 1'b0;
`ifdef COLLECTOR_OVERFLOW_CNT_EN
            drop_count <= 16'h0000;
`endif
        end else begin
            fs_reg   <= frame_start;
            overflow <= 1'b0;

            if (release_bank) begin
                bank_full[rd_bank] <= 1'b0;
            end

            case (wr_state)
                W_IDLE: begin
                    if (fs_rise) begin
                        if (bank_free) begin
                            wr_state <= W_FILL;
                            wr_addr  <= '0;
                        end else begin
                            // Whole frame dropped: its pairs arrive while we
                            // sit in W_IDLE and are ignored.
                            overflow <= 1'b1;
`ifdef COLLECTOR_OVERFLOW_CNT_EN
                            if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 16'd1;
                            end
`endif
                        end
                    end
                end
                W_FILL: begin
                    if (in_valid) begin
                        if (wr_addr == PAIR_LAST) begin
                            wr_state <= W_DONE;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(2);
                        end
                    end
                end
                W_DONE: begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                    wr_addr            <= '0;
                    wr_state           <= W_IDLE;
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------- read / stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_active  <= 1'b0;
            rd_bank    <= 1'b0;
            fetch_addr <= '0;
            fetch_done <= 1'b0;
            ram_valid  <= 1'b0;
            ram_last   <= 1'b0;
            ram_odd    <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            ram_valid <= rd_en;
            ram_last  <= rd_is_last;
            ram_odd   <= rd_odd;

            if (!out_valid || pop) begin
                // Output register free this cycle: the prefetch register is
                // older than the RAM stage, so it goes first.
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    out_valid  <= 1'b1;
                    skid_valid <= ram_valid;
                    skid_data  <= ram_data;
                    skid_last  <= ram_last;
                end else if (ram_valid) begin
                    out_data  <= ram_data;
                    out_last  <= ram_last;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (ram_valid) begin
                // Output stalled: park the arriving sample.
                skid_valid <= 1'b1;
                skid_data  <= ram_data;
                skid_last  <= ram_last;
            end

            if (start) begin
                rd_active  <= 1'b1;
                fetch_done <= 1'b0;
                fetch_addr <= ADDR_W'(1);
            end else if (rd_en) begin
                if (fetch_addr == LAST_ADDR) begin
                    fetch_done <= 1'b1;
                end else begin
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
            end

            if (release_bank) begin
                rd_active  <= 1'b0;
                rd_bank    <= ~rd_bank;
                fetch_addr <= '0;
            end
        end
    end

endmodule
